// File: rtl/instr_issue_writeback.sv
// Purpose: three-stage issue/writeback sequencer around a 4x4-bit register file.
// Latency: instruction accepted at edge N is written back at edge N+2.
// Backpressure: instr_ready deasserts in ISSUE/WB and while a direct load is requested.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr_valid / instr / instr_ready  instruction handshake; instr = {op, rd, rs, rt}
//   ld_en / ld_addr / ld_data       direct register load, honoured only in IDLE
//   ex_op_code / ex_rs / ex_rt      operands to the execute stage (valid in ISSUE only)
//   ex_rd                           combinational execute result, sampled at end of ISSUE
//   wb_valid / wb_addr / wb_data    writeback pulse and payload (WB only)
//   dbg_addr / dbg_data             combinational register file read
//   retired                         saturating count of written-back instructions
module instr_issue_writeback #(
   parameter logic [3:0] RESET_VAL = 4'b0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   input  logic [8:0] instr,
   output logic       instr_ready,
   input  logic       ld_en,
   input  logic [1:0] ld_addr,
   input  logic [3:0] ld_data,
   output logic [2:0] ex_op_code,
   output logic [3:0] ex_rs,
   output logic [3:0] ex_rt,
   input  logic [3:0] ex_rd,
   output logic       wb_valid,
   output logic [1:0] wb_addr,
   output logic [3:0] wb_data,
   input  logic [1:0] dbg_addr,
   output logic [3:0] dbg_data,
   output logic [7:0] retired
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WB    = 2'd2
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] regfile [4];
   logic [8:0] instr_q;
   logic [3:0] result_q;
   logic [7:0] retired_q;

   logic [2:0] op_f;
   logic [1:0] rd_f;
   logic [1:0] rs_f;
   logic [1:0] rt_f;
   logic       accept;

   assign op_f = instr_q[8:6];
   assign rd_f = instr_q[5:4];
   assign rs_f = instr_q[3:2];
   assign rt_f = instr_q[1:0];

   // A pending load takes priority over an offered instruction in IDLE.
   assign instr_ready = (state_q == IDLE) && !ld_en;
   assign accept      = instr_valid && instr_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath outputs
   always_comb begin
      state_d    = state_q;
      ex_op_code = 3'b000;
      ex_rs      = 4'b0000;
      ex_rt      = 4'b0000;
      wb_valid   = 1'b0;
      wb_addr    = 2'b00;
      wb_data    = 4'b0000;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            ex_op_code = op_f;
            ex_rs      = regfile[rs_f];
            ex_rt      = regfile[rt_f];
            state_d    = WB;
         end
         WB: begin
            wb_valid = 1'b1;
            wb_addr  = rd_f;
            wb_data  = result_q;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Instruction latch and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q  <= 9'd0;
         result_q <= 4'd0;
      end else begin
         if (accept) begin
            instr_q <= instr;
         end
         // ex_rd is only meaningful while operands are presented.
         if (state_q == ISSUE) begin
            result_q <= ex_rd;
         end
      end
   end

   // Register file: loads in IDLE, writeback in WB; the two never coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            regfile[i] <= RESET_VAL;
         end
      end else begin
         if ((state_q == IDLE) && ld_en) begin
            regfile[ld_addr] <= ld_data;
         end else if (state_q == WB) begin
            regfile[rd_f] <= result_q;
         end
      end
   end

   // Retired counter, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= 8'd0;
      end else if ((state_q == WB) && (retired_q != 8'hFF)) begin
         retired_q <= retired_q + 8'd1;
      end
   end

   assign retired  = retired_q;
   assign dbg_data = regfile[dbg_addr];

endmodule

// File: doc/instr_issue_writeback.md
INSTR_ISSUE_WRITEBACK -- requirements
Module: instr_issue_writeback

Interface
REQ-001 Parameter: RESET_VAL, default 4'b0000, value loaded into every register-file entry on reset.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: instr_valid  input  1  instruction offered.
REQ-005 Port: instr  input  9  {op[8:6], rd_addr[5:4], rs_addr[3:2], rt_addr[1:0]}.
REQ-006 Port: instr_ready  output  1  instruction accepted on edge when instr_valid & instr_ready.
REQ-007 Port: ld_en  input  1  direct register load request.
REQ-008 Port: ld_addr  input  2  load target register.
REQ-009 Port: ld_data  input  4  load value.
REQ-010 Port: ex_op_code  output  3  op code to the execute stage.
REQ-011 Port: ex_rs  output  4  first operand to the execute stage.
REQ-012 Port: ex_rt  output  4  second operand to the execute stage.
REQ-013 Port: ex_rd  input  4  combinational result from the execute stage.
REQ-014 Port: wb_valid  output  1  one-cycle pulse, register write this edge.
REQ-015 Port: wb_addr  output  2  register being written.
REQ-016 Port: wb_data  output  4  value being written.
REQ-017 Port: dbg_addr  input  2  debug read address.
REQ-018 Port: dbg_data  output  4  combinational read of regfile[dbg_addr].
REQ-019 Port: retired  output  8  count of completed instructions.

Function
REQ-020 The block SHALL hold a 4-entry x 4-bit register file, an instruction latch, a 4-bit result register, and a 3-state FSM: IDLE, ISSUE, WB.
REQ-021 instr_ready SHALL equal (state==IDLE) & ~ld_en.
REQ-022 IDLE: on instr_valid & instr_ready, the block SHALL latch instr and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-023 IDLE with ld_en=1: the block SHALL write regfile[ld_addr] <= ld_data on that edge; ld_en in ISSUE/WB SHALL be ignored.
REQ-024 ISSUE, exactly one cycle: ex_op_code=latched op, ex_rs=regfile[rs_addr], ex_rt=regfile[rt_addr]; result register <= ex_rd at the cycle end; next state WB.
REQ-025 Outside ISSUE: ex_op_code=3'b000, ex_rs=4'b0000, ex_rt=4'b0000.
REQ-026 WB, exactly one cycle: wb_valid=1, wb_addr=latched rd_addr, wb_data=result register; regfile[rd_addr] <= wb_data on the edge; retired increments; next state IDLE.
REQ-027 Outside WB: wb_valid=0, wb_addr=0, wb_data=0.
REQ-028 Latency: instruction accepted at edge N is written at edge N+2. Throughput SHALL be one instruction per 3 cycles.
REQ-029 rd_addr equal to rs_addr and/or rt_addr SHALL use pre-write operands; no forwarding is needed.
REQ-030 dbg_data SHALL show the pre-edge value during the WB or load cycle and the new value after the edge.
REQ-031 retired SHALL saturate at 8'hFF.
REQ-032 ex_rd SHALL be sampled only at the end of ISSUE; ex_rd values in other cycles have no effect.

Reset
REQ-033 rst_n=0 SHALL at once force: state IDLE, regfile entries RESET_VAL, instruction latch 0, result 0, retired 0, wb_valid 0, and ex_* 0.
REQ-034 Reset asserted in ISSUE or WB SHALL abort the instruction with no register write and no wb_valid pulse.
REQ-035 After rst_n rises, instr_ready SHALL be 1 in the first cycle, unless ld_en=1.

Verification
REQ-036 Reset: rst_n low -> dbg_data=0 for all four addresses, retired=0, instr_ready=1 after release.
REQ-037 Load r1=3 and r2=5, then issue instr {000,11,01,10} with the execute stub returning 8: ISSUE shows ex_rs=3, ex_rt=5; wb_valid, wb_addr=3, wb_data=8 two edges after accept; dbg r3=8; retired=1.
REQ-038 instr_valid held high for 3 instructions -> accepts every 3rd cycle, instr_ready=0 during ISSUE/WB, 3 wb_valid pulses.
REQ-039 ld_en and instr_valid both high in IDLE -> load done, instr_ready=0, instruction accepted on the next cycle with the loaded value as operand.
REQ-040 rst_n pulsed low during ISSUE of an instr targeting r2 (r2 preloaded to 7) -> no wb_valid, r2 returns to RESET_VAL, state IDLE.
REQ-041 260 back-to-back instructions -> retired stops at 255.
